// File: rtl/cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmd_sequencer                                          |
// | Description : Buffers 16-bit commands in a small FIFO and issues     |
// |               them one at a time to the command UART transmitter.    |
// |               Each command waits for a response byte; NAK or         |
// |               timeout triggers a retry, and exhausted retries halt   |
// |               in a sticky error until cleared.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cmd_sequencer #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] ACK       = 8'hA5,
    parameter int         TO_CYCLES = 1000000,
    parameter int         MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [15:0]            push_cmd,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            cmd,
    output logic                   send_cmd,
    input  logic                   cmd_sent,
    input  logic                   resp_rdy,
    input  logic [7:0]             resp,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             last_resp,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic                   ovf,
    input  logic                   clr_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = $clog2(TO_CYCLES + 1);
    localparam int c_RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(DEPTH);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TO_CYCLES - 1);
    localparam logic [c_RW-1:0] c_MAX_RETRY = c_RW'(MAX_RETRY);

    localparam logic [1:0] c_ERR_TO  = 2'b01;
    localparam logic [1:0] c_ERR_NAK = 2'b10;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_LAUNCH    = 3'd1;
    localparam logic [2:0] c_TX_WAIT   = 3'd2;
    localparam logic [2:0] c_RESP_WAIT = 3'd3;
    localparam logic [2:0] c_ERROR     = 3'd4;

    logic [15:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [15:0]     r_cmd;
    logic [c_TW-1:0] r_to_cnt;
    logic [c_RW-1:0] r_retry;
    logic            r_done;
    logic [7:0]      r_last_resp;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic            r_ovf;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_resp_ok;
    logic w_ack;
    logic w_nak;
    logic w_timeout;
    logic w_fail;
    logic w_can_retry;
    logic w_clr_fail;
    logic w_pop;

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    // A push into a full FIFO is dropped even when a pop frees a slot the same cycle.
    assign w_push_ok = push && !w_full;

    // Responses only count while waiting for one; stale bytes in TX_WAIT are ignored.
    assign w_resp_ok   = (r_state == c_RESP_WAIT) && resp_rdy;
    assign w_ack       = w_resp_ok && (resp == ACK);
    assign w_nak       = w_resp_ok && (resp != ACK);
    // A response arriving on the final timeout cycle takes precedence.
    assign w_timeout   = ((r_state == c_TX_WAIT) || (r_state == c_RESP_WAIT)) &&
                         (r_to_cnt == c_TO_LAST) && !w_resp_ok;
    assign w_fail      = w_nak || w_timeout;
    assign w_can_retry = (r_retry < c_MAX_RETRY);
    assign w_clr_fail  = (r_state == c_ERROR) && clr_err;
    assign w_pop       = w_ack || w_clr_fail;

    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign cmd       = r_cmd;
    assign done      = r_done;
    assign last_resp = r_last_resp;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign ovf       = r_ovf;

    // FIFO storage: written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_cmd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (!w_empty) begin
                    w_next_state = c_LAUNCH;
                end
            end
            c_LAUNCH: begin
                w_next_state = c_TX_WAIT;
            end
            c_TX_WAIT: begin
                if (w_timeout) begin
                    w_next_state = w_can_retry ? c_LAUNCH : c_ERROR;
                end else if (cmd_sent) begin
                    w_next_state = c_RESP_WAIT;
                end
            end
            c_RESP_WAIT: begin
                if (w_ack) begin
                    w_next_state = c_IDLE;
                end else if (w_fail) begin
                    w_next_state = w_can_retry ? c_LAUNCH : c_ERROR;
                end
            end
            c_ERROR: begin
                if (clr_err) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        send_cmd = 1'b0;
        busy     = 1'b1;
        case (r_state)
            c_IDLE:   busy     = 1'b0;
            c_LAUNCH: send_cmd = 1'b1;
            default:  ;
        endcase
    end

    // Command register: captured from the head when leaving IDLE, held through retries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
        end else if ((r_state == c_IDLE) && !w_empty) begin
            r_cmd <= r_mem[r_rd_ptr];
        end
    end

    // Timeout counter: restarts on every launch, runs while awaiting TX and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == c_LAUNCH) begin
            r_to_cnt <= '0;
        end else if ((r_state == c_TX_WAIT) || (r_state == c_RESP_WAIT)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Retry counter, response capture, done pulse and sticky error/overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry     <= '0;
            r_done      <= 1'b0;
            r_last_resp <= 8'h00;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= w_ack;
            if (w_resp_ok) begin
                r_last_resp <= resp;
            end
            if (w_ack || w_clr_fail) begin
                r_retry <= '0;
            end else if (w_fail && w_can_retry) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_fail && !w_can_retry) begin
                r_err      <= 1'b1;
                r_err_code <= w_timeout ? c_ERR_TO : c_ERR_NAK;
            end else if (w_clr_fail) begin
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
            end
            // A dropped push in the same cycle as clr_err keeps the flag set.
            if (push && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cmd_sequencer                                       |
// | Description : Self-checking bench for cmd_sequencer with a simple    |
// |               transmitter/responder model and a command scoreboard.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_cmd_sequencer;

    localparam int         DEPTH = 4;
    localparam int         TO    = 100;
    localparam logic [7:0] ACKV  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic [15:0] push_cmd;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic        done;
    logic [7:0]  last_resp;
    logic        err;
    logic [1:0]  err_code;
    logic        ovf;
    logic        clr_err;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_send = 0;
    int n_done = 0;

    logic [15:0] exp_q  [$];
    logic [15:0] sent_q [$];
    int          sent_t [$];

    cmd_sequencer #(
        .DEPTH     (DEPTH),
        .ACK       (ACKV),
        .TO_CYCLES (TO),
        .MAX_RETRY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_cmd  (push_cmd),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .cmd       (cmd),
        .send_cmd  (send_cmd),
        .cmd_sent  (cmd_sent),
        .resp_rdy  (resp_rdy),
        .resp      (resp),
        .busy      (busy),
        .done      (done),
        .last_resp (last_resp),
        .err       (err),
        .err_code  (err_code),
        .ovf       (ovf),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every issued command with its cycle, and done pulses.
    always @(negedge clk) begin
        if (send_cmd === 1'b1) begin
            sent_q.push_back(cmd);
            sent_t.push_back(cyc);
            n_send++;
        end
        if (done === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next issued command; returns its launch cycle and value.
    task automatic wait_send(output int t, output logic [15:0] c);
        int k = 0;
        while (sent_q.size() == 0 && k < 400) begin
            tick();
            k++;
        end
        if (sent_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_send: no send_cmd within %0d cycles, required one", k);
            t = cyc;
            c = 16'hxxxx;
        end else begin
            t = sent_t.pop_front();
            c = sent_q.pop_front();
        end
    endtask

    // Transmitter model: raise cmd_sent for one cycle at absolute cycle t.
    task automatic tx_at(input int t);
        while (cyc < t) tick();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
    endtask

    // Responder model: present one response byte at absolute cycle t.
    task automatic resp_at(input int t, input logic [7:0] v);
        while (cyc < t) tick();
        resp_rdy = 1'b1;
        resp     = v;
        tick();
        resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b0; push_cmd = '0; cmd_sent = 1'b0;
        resp_rdy = 1'b0; resp = '0; clr_err = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({count, empty, full, busy, send_cmd, done, err, err_code, ovf} !== 12'b000_1_0_0_0_0_0_00_0) begin
            n_miss++;
            $display("FAIL reset_flags: got %b, want 000100000000",
                     {count, empty, full, busy, send_cmd, done, err, err_code, ovf});
        end
        n_vec++;
        if (cmd !== 16'h0000) begin n_miss++; $display("FAIL reset_cmd: got %h, want 0000", cmd); end
        n_vec++;
        if (last_resp !== 8'h00) begin n_miss++; $display("FAIL reset_last_resp: got %h, want 00", last_resp); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int p, t, s0, d0;
        logic [15:0] c, e;
        s0 = n_send; d0 = n_done;
        p = cyc;
        push = 1'b1; push_cmd = 16'h2345; exp_q.push_back(16'h2345);
        tick();
        push = 1'b0;
        wait_send(t, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e) begin n_miss++; $display("FAIL single_cmd: got %h, want %h", c, e); end
        n_vec++;
        if (t !== p + 2) begin n_miss++; $display("FAIL single_latency: got cycle %0d, want %0d", t, p + 2); end
        tx_at(t + 41);
        resp_at(t + 46, ACKV);
        n_vec++;
        if (done !== 1'b1) begin n_miss++; $display("FAIL single_done: got %b, want 1", done); end
        repeat (10) tick();
        n_vec++;
        if ({count, err, last_resp} !== {3'd0, 1'b0, 8'hA5}) begin
            n_miss++;
            $display("FAIL single_after: got count=%0d err=%b last_resp=%h, want 0 0 a5", count, err, last_resp);
        end
        n_vec++;
        if ((n_send - s0) !== 1 || (n_done - d0) !== 1) begin
            n_miss++;
            $display("FAIL single_pulses: got sends=%0d dones=%0d, want 1 1", n_send - s0, n_done - d0);
        end
    endtask

    task automatic test_fill_overflow();
        int t;
        logic [15:0] c, e;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                n_vec++;
                if ({full, count} !== {1'b1, 3'd4}) begin
                    n_miss++;
                    $display("FAIL fill_full: got full=%b count=%0d, want 1 4", full, count);
                end
            end
            push = 1'b1; push_cmd = 16'(k);
            if (k <= DEPTH) exp_q.push_back(16'(k));
            tick();
        end
        push = 1'b0;
        n_vec++;
        if ({ovf, count} !== {1'b1, 3'd4}) begin
            n_miss++;
            $display("FAIL fill_ovf: got ovf=%b count=%0d, want 1 4", ovf, count);
        end
        for (int k = 0; k < DEPTH; k++) begin
            wait_send(t, c);
            e = exp_q.pop_front();
            n_vec++;
            if (c !== e) begin n_miss++; $display("FAIL fill_order%0d: got %h, want %h", k, c, e); end
            tx_at(t + 5);
            resp_at(t + 10, ACKV);
            n_vec++;
            if (done !== 1'b1) begin n_miss++; $display("FAIL fill_done%0d: got %b, want 1", k, done); end
        end
        repeat (20) tick();
        n_vec++;
        if (sent_q.size() !== 0 || count !== 3'd0 || ovf !== 1'b1) begin
            n_miss++;
            $display("FAIL fill_dropped: got extra_sends=%0d count=%0d ovf=%b, want 0 0 1", sent_q.size(), count, ovf);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_vec++;
        if ({ovf, err, busy} !== 3'b000) begin
            n_miss++;
            $display("FAIL fill_clr_ovf: got ovf=%b err=%b busy=%b, want 000", ovf, err, busy);
        end
    endtask

    task automatic test_nak_retry();
        int t1, t2, d0;
        logic [15:0] c, e;
        d0 = n_done;
        push = 1'b1; push_cmd = 16'hBEEF;
        exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF);
        tick();
        push = 1'b0;
        wait_send(t1, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e) begin n_miss++; $display("FAIL nak_first: got %h, want %h", c, e); end
        tx_at(t1 + 3);
        resp_at(t1 + 6, 8'h5A);
        n_vec++;
        if ({done, err, last_resp} !== {1'b0, 1'b0, 8'h5A}) begin
            n_miss++;
            $display("FAIL nak_resp: got done=%b err=%b last=%h, want 0 0 5a", done, err, last_resp);
        end
        wait_send(t2, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e) begin n_miss++; $display("FAIL nak_resend: got %h, want %h", c, e); end
        tx_at(t2 + 3);
        resp_at(t2 + 6, ACKV);
        repeat (5) tick();
        n_vec++;
        if ({err, last_resp} !== {1'b0, 8'hA5} || (n_done - d0) !== 1 || sent_q.size() !== 0) begin
            n_miss++;
            $display("FAIL nak_final: got err=%b last=%h dones=%0d extra=%0d, want 0 a5 1 0",
                     err, last_resp, n_done - d0, sent_q.size());
        end
    endtask

    task automatic test_exhausted();
        int t;
        logic [15:0] c, e;
        push = 1'b1; push_cmd = 16'hC0DE;
        repeat (3) exp_q.push_back(16'hC0DE);
        tick();
        push = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_send(t, c);
            e = exp_q.pop_front();
            n_vec++;
            if (c !== e) begin n_miss++; $display("FAIL exh_try%0d: got %h, want %h", k, c, e); end
            tx_at(t + 3);
            resp_at(t + 6, 8'h00);
        end
        n_vec++;
        if ({err, err_code, busy} !== {1'b1, 2'b10, 1'b1}) begin
            n_miss++;
            $display("FAIL exh_err: got err=%b code=%b busy=%b, want 1 10 1", err, err_code, busy);
        end
        push = 1'b1; push_cmd = 16'hD00D;
        tick();
        push = 1'b0;
        repeat (10) tick();
        n_vec++;
        if (sent_q.size() !== 0 || count !== 3'd2 || err !== 1'b1) begin
            n_miss++;
            $display("FAIL exh_halt: got sends=%0d count=%0d err=%b, want 0 2 1", sent_q.size(), count, err);
        end
        clr_err = 1'b1; exp_q.push_back(16'hD00D);
        tick();
        clr_err = 1'b0;
        n_vec++;
        if ({err, err_code, count} !== {1'b0, 2'b00, 3'd1}) begin
            n_miss++;
            $display("FAIL exh_clr: got err=%b code=%b count=%0d, want 0 00 1", err, err_code, count);
        end
        wait_send(t, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e) begin n_miss++; $display("FAIL exh_next: got %h, want %h", c, e); end
        tx_at(t + 3);
        resp_at(t + 6, ACKV);
        n_vec++;
        if (done !== 1'b1) begin n_miss++; $display("FAIL exh_next_done: got %b, want 1", done); end
    endtask

    task automatic test_timeout();
        int t1, t2, t3;
        logic [15:0] c, e;
        tick();
        push = 1'b1; push_cmd = 16'h7070;
        repeat (3) exp_q.push_back(16'h7070);
        tick();
        push = 1'b0;
        wait_send(t1, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e) begin n_miss++; $display("FAIL to_first: got %h, want %h", c, e); end
        wait_send(t2, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e || (t2 - t1) !== TO + 1) begin
            n_miss++;
            $display("FAIL to_retry1: got %h after %0d cycles, want %h after %0d", c, t2 - t1, e, TO + 1);
        end
        tx_at(t2 + 5);
        wait_send(t3, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e || (t3 - t2) !== TO + 1) begin
            n_miss++;
            $display("FAIL to_retry2: got %h after %0d cycles, want %h after %0d", c, t3 - t2, e, TO + 1);
        end
        tx_at(t3 + 5);
        while (cyc < t3 + TO) tick();
        n_vec++;
        if (err !== 1'b0) begin n_miss++; $display("FAIL to_early: got err=%b, want 0", err); end
        tick();
        n_vec++;
        if ({err, err_code} !== {1'b1, 2'b01}) begin
            n_miss++;
            $display("FAIL to_err: got err=%b code=%b, want 1 01", err, err_code);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_vec++;
        if ({err, count, busy} !== {1'b0, 3'd0, 1'b0}) begin
            n_miss++;
            $display("FAIL to_clr: got err=%b count=%0d busy=%b, want 0 0 0", err, count, busy);
        end
    endtask

    task automatic test_resp_on_timeout();
        int t;
        logic [15:0] c, e;
        push = 1'b1; push_cmd = 16'h0F0F; exp_q.push_back(16'h0F0F);
        tick();
        push = 1'b0;
        wait_send(t, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e) begin n_miss++; $display("FAIL edge_cmd: got %h, want %h", c, e); end
        tx_at(t + 10);
        resp_at(t + TO, ACKV);
        n_vec++;
        if ({done, err} !== 2'b10) begin
            n_miss++;
            $display("FAIL edge_ack: got done=%b err=%b, want 1 0", done, err);
        end
        repeat (TO + 10) tick();
        n_vec++;
        if (sent_q.size() !== 0 || err !== 1'b0) begin
            n_miss++;
            $display("FAIL edge_no_retry: got sends=%0d err=%b, want 0 0", sent_q.size(), err);
        end
    endtask

    task automatic test_reset_midop();
        int t, d0;
        logic [15:0] c, e;
        for (int k = 0; k < 3; k++) begin
            push = 1'b1; push_cmd = 16'hA1 + 16'(k); exp_q.push_back(16'hA1 + 16'(k));
            tick();
        end
        push = 1'b0;
        wait_send(t, c);
        e = exp_q.pop_front();
        n_vec++;
        if (c !== e) begin n_miss++; $display("FAIL rst_first: got %h, want %h", c, e); end
        tx_at(t + 3);
        n_vec++;
        if ({busy, count} !== {1'b1, 3'd3}) begin
            n_miss++;
            $display("FAIL rst_before: got busy=%b count=%0d, want 1 3", busy, count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        d0 = n_done;
        n_vec++;
        if ({busy, count, send_cmd, empty} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
            n_miss++;
            $display("FAIL rst_after: got busy=%b count=%0d send=%b empty=%b, want 0 0 0 1",
                     busy, count, send_cmd, empty);
        end
        resp_at(cyc + 2, ACKV);
        repeat (20) tick();
        n_vec++;
        if ((n_done - d0) !== 0 || sent_q.size() !== 0) begin
            n_miss++;
            $display("FAIL rst_quiet: got dones=%0d sends=%0d, want 0 0", n_done - d0, sent_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_nak_retry();
        test_exhausted();
        test_timeout();
        test_resp_on_timeout();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
